// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch control sequencer: state encoding and defaults.
package stopwatch_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_IDLE  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_LAP   = 3'd4
  } state_t;

  localparam int unsigned TICK_HZ_DEFAULT = 100;

  // RUN and LAP both keep the chain counting; LAP only freezes the display.
  function automatic logic is_counting(input state_t s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_button_conditioner.sv
// Raw push-button to single-cycle press pulse: 2-FF synchroniser, debounce, rising-edge detect.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 10_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_d;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      // Any cycle where the input agrees with the accepted level restarts the count.
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_pulse = r_level & ~r_level_d;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button conditioning, 100 Hz prescaler and RUN/PAUSE/LAP/CLEAR FSM.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 10_000_000,
  parameter int unsigned TICK_HZ         = TICK_HZ_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = 10_000,
  localparam int unsigned DIV            = CLK_HZ / TICK_HZ,
  localparam int unsigned PW             = $clog2(DIV)
) (
  input  logic          clk,
  input  logic          res_n,
  input  logic          btn_start_stop,
  input  logic          btn_lap_reset,
  output logic          chain_ena,
  output logic          chain_res,
  output logic          freeze,
  output logic          running,
  output state_t        o_dbg_state,
  output logic [PW-1:0] o_dbg_pcnt
);

  localparam logic [PW-1:0] PCNT_MAX = PW'(DIV - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_pcnt;
  logic          w_ss;
  logic          w_lr;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_ss (
    .i_clk   (clk),
    .i_rst_n (res_n),
    .i_btn   (btn_start_stop),
    .o_pulse (w_ss)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_lr (
    .i_clk   (clk),
    .i_rst_n (res_n),
    .i_btn   (btn_lap_reset),
    .o_pulse (w_lr)
  );

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_state <= ST_CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // start_stop is tested first everywhere, so it wins over a simultaneous lap_reset.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR: w_state_nxt = ST_IDLE;
      ST_IDLE:  if (w_ss) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_ss)      w_state_nxt = ST_PAUSE;
        else if (w_lr) w_state_nxt = ST_LAP;
      end
      ST_LAP: begin
        if (w_ss)      w_state_nxt = ST_PAUSE;
        else if (w_lr) w_state_nxt = ST_RUN;
      end
      ST_PAUSE: begin
        if (w_ss)      w_state_nxt = ST_RUN;
        else if (w_lr) w_state_nxt = ST_CLEAR;
      end
      default: w_state_nxt = ST_CLEAR;
    endcase
  end

  // PAUSE keeps the partial tick so a resume continues the same centisecond.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_pcnt <= '0;
    end else if (is_counting(r_state)) begin
      r_pcnt <= (r_pcnt == PCNT_MAX) ? '0 : r_pcnt + 1'b1;
    end else if (r_state != ST_PAUSE) begin
      r_pcnt <= '0;
    end
  end

  assign chain_ena   = is_counting(r_state) && (r_pcnt == PCNT_MAX);
  assign chain_res   = (r_state == ST_CLEAR);
  assign freeze      = (r_state == ST_LAP);
  assign running     = is_counting(r_state);
  assign o_dbg_state = r_state;
  assign o_dbg_pcnt  = r_pcnt;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DIV=4 and a 3-cycle debounce.
module tb_stopwatch_ctrl;
  import stopwatch_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       res_n = 1'b1;
  logic       btn_start_stop = 1'b0;
  logic       btn_lap_reset = 1'b0;
  logic       chain_ena;
  logic       chain_res;
  logic       freeze;
  logic       running;
  state_t     dbg_state;
  logic [1:0] dbg_pcnt;
  wire  [3:0] outs = {chain_res, chain_ena, freeze, running};

  int n_cmp = 0;
  int n_err = 0;

  stopwatch_ctrl #(
    .CLK_HZ          (400),
    .TICK_HZ         (100),
    .DEBOUNCE_CYCLES (3)
  ) dut (
    .clk            (clk),
    .res_n          (res_n),
    .btn_start_stop (btn_start_stop),
    .btn_lap_reset  (btn_lap_reset),
    .chain_ena      (chain_ena),
    .chain_res      (chain_res),
    .freeze         (freeze),
    .running        (running),
    .o_dbg_state    (dbg_state),
    .o_dbg_pcnt     (dbg_pcnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic do_reset();
    btn_start_stop = 1'b0;
    btn_lap_reset  = 1'b0;
    @(negedge clk);
    res_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 res_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // From IDLE: press start_stop; returns on the first RUN cycle (pcnt 0) with the button released.
  task automatic go_run();
    btn_start_stop = 1'b1;
    repeat (6) @(negedge clk);
    btn_start_stop = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    #2 res_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (outs !== 4'b1000) begin n_err++; $display("FAIL reset_outs: got %b expected %b", outs, 4'b1000); end
    n_cmp++; if (dbg_state !== ST_CLEAR) begin n_err++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_CLEAR); end
    n_cmp++; if (dbg_pcnt !== 2'd0) begin n_err++; $display("FAIL reset_pcnt: got %0d expected 0", dbg_pcnt); end
    @(posedge clk);
    #1 res_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (outs !== 4'b1000) begin n_err++; $display("FAIL clear_cycle_outs: got %b expected %b", outs, 4'b1000); end
    @(negedge clk);
    n_cmp++; if (outs !== 4'b0000) begin n_err++; $display("FAIL idle_outs: got %b expected %b", outs, 4'b0000); end
    n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL idle_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (chain_ena !== 1'b0 || running !== 1'b0 || dbg_state !== ST_IDLE) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL idle_100_quiet: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_start();
    int pulses;
    int cad_err;
    btn_start_stop = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL start_latency_early: got %0d expected %0d", dbg_state, ST_IDLE); end
    @(negedge clk);
    n_cmp++; if (dbg_state !== ST_RUN) begin n_err++; $display("FAIL start_run: got %0d expected %0d", dbg_state, ST_RUN); end
    n_cmp++; if (outs !== 4'b0001) begin n_err++; $display("FAIL start_outs: got %b expected %b", outs, 4'b0001); end
    n_cmp++; if (dbg_pcnt !== 2'd0) begin n_err++; $display("FAIL start_pcnt: got %0d expected 0", dbg_pcnt); end
    pulses = 0;
    cad_err = 0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 4) btn_start_stop = 1'b0;
      if (chain_ena) pulses++;
      if (chain_ena !== ((i % 4) == 3)) cad_err++;
    end
    n_cmp++; if (pulses !== 10) begin n_err++; $display("FAIL run_pulses_40: got %0d expected 10", pulses); end
    n_cmp++; if (cad_err !== 0) begin n_err++; $display("FAIL run_cadence: got %0d off-phase cycles expected 0", cad_err); end
    n_cmp++; if (dbg_state !== ST_RUN) begin n_err++; $display("FAIL release_no_pulse: got %0d expected %0d", dbg_state, ST_RUN); end
  endtask

  task automatic test_glitch();
    int bad;
    do_reset();
    go_run();
    repeat (4) @(negedge clk);
    btn_start_stop = 1'b1;
    repeat (2) @(negedge clk);
    btn_start_stop = 1'b0;
    bad = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (dbg_state !== ST_RUN) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL glitch_ignored: got %0d non-RUN cycles expected 0", bad); end
    btn_start_stop = 1'b1;
    @(negedge clk);
    btn_start_stop = 1'b0;
    @(negedge clk);
    btn_start_stop = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++; if (dbg_state !== ST_RUN) begin n_err++; $display("FAIL bounce_early: got %0d expected %0d", dbg_state, ST_RUN); end
    @(negedge clk);
    n_cmp++; if (dbg_state !== ST_PAUSE) begin n_err++; $display("FAIL bounce_pause: got %0d expected %0d", dbg_state, ST_PAUSE); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 5) btn_start_stop = 1'b0;
      if (dbg_state !== ST_PAUSE) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL bounce_single_pulse: got %0d non-PAUSE cycles expected 0", bad); end
  endtask

  task automatic test_lap();
    int pulses;
    int cad_err;
    int hold_err;
    do_reset();
    go_run();
    @(negedge clk);
    btn_lap_reset = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++; if (dbg_state !== ST_RUN || freeze !== 1'b0) begin n_err++; $display("FAIL lap_early: got state %0d freeze %b expected %0d 0", dbg_state, freeze, ST_RUN); end
    @(negedge clk);
    n_cmp++; if (dbg_state !== ST_LAP) begin n_err++; $display("FAIL lap_state: got %0d expected %0d", dbg_state, ST_LAP); end
    n_cmp++; if (outs !== 4'b0111) begin n_err++; $display("FAIL lap_outs: got %b expected %b", outs, 4'b0111); end
    btn_lap_reset = 1'b0;
    pulses = 0;
    cad_err = 0;
    hold_err = 0;
    for (int t = 8; t <= 23; t++) begin
      @(negedge clk);
      if (chain_ena) pulses++;
      if (chain_ena !== ((t % 4) == 3)) cad_err++;
      if (freeze !== 1'b1) hold_err++;
    end
    n_cmp++; if (pulses !== 4 || cad_err !== 0) begin n_err++; $display("FAIL lap_cadence: got %0d pulses %0d off-phase expected 4 0", pulses, cad_err); end
    n_cmp++; if (hold_err !== 0) begin n_err++; $display("FAIL lap_freeze_held: got %0d drops expected 0", hold_err); end
    @(negedge clk);
    btn_lap_reset = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++; if (freeze !== 1'b1) begin n_err++; $display("FAIL lap_release_early: got %b expected 1", freeze); end
    @(negedge clk);
    n_cmp++; if (dbg_state !== ST_RUN || freeze !== 1'b0) begin n_err++; $display("FAIL lap_release: got state %0d freeze %b expected %0d 0", dbg_state, freeze, ST_RUN); end
    n_cmp++; if (dbg_pcnt !== 2'd2) begin n_err++; $display("FAIL lap_release_pcnt: got %0d expected 2", dbg_pcnt); end
    btn_lap_reset = 1'b0;
  endtask

  task automatic test_pause();
    int bad;
    do_reset();
    go_run();
    repeat (4) @(negedge clk);
    btn_start_stop = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++; if (dbg_state !== ST_RUN || dbg_pcnt !== 2'd1) begin n_err++; $display("FAIL pause_early: got state %0d pcnt %0d expected %0d 1", dbg_state, dbg_pcnt, ST_RUN); end
    @(negedge clk);
    n_cmp++; if (dbg_state !== ST_PAUSE || outs !== 4'b0000) begin n_err++; $display("FAIL pause_enter: got state %0d outs %b expected %0d 0000", dbg_state, outs, ST_PAUSE); end
    n_cmp++; if (dbg_pcnt !== 2'd2) begin n_err++; $display("FAIL pause_pcnt: got %0d expected 2", dbg_pcnt); end
    btn_start_stop = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (chain_ena !== 1'b0 || dbg_pcnt !== 2'd2 || dbg_state !== ST_PAUSE) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL pause_hold: got %0d bad cycles expected 0", bad); end
    @(negedge clk);
    btn_start_stop = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++; if (dbg_state !== ST_PAUSE || chain_ena !== 1'b0) begin n_err++; $display("FAIL resume_early: got state %0d ena %b expected %0d 0", dbg_state, chain_ena, ST_PAUSE); end
    @(negedge clk);
    n_cmp++; if (dbg_state !== ST_RUN || outs !== 4'b0001 || dbg_pcnt !== 2'd2) begin n_err++; $display("FAIL resume: got state %0d outs %b pcnt %0d expected %0d 0001 2", dbg_state, outs, dbg_pcnt, ST_RUN); end
    btn_start_stop = 1'b0;
    @(negedge clk);
    n_cmp++; if (chain_ena !== 1'b1) begin n_err++; $display("FAIL resume_first_tick: got %b expected 1", chain_ena); end
    repeat (4) @(negedge clk);
    btn_start_stop = 1'b1;
    repeat (6) @(negedge clk);
    n_cmp++; if (dbg_state !== ST_PAUSE || dbg_pcnt !== 2'd1) begin n_err++; $display("FAIL repause: got state %0d pcnt %0d expected %0d 1", dbg_state, dbg_pcnt, ST_PAUSE); end
    btn_start_stop = 1'b0;
    @(negedge clk);
    btn_lap_reset = 1'b1;
    repeat (6) @(negedge clk);
    n_cmp++; if (dbg_state !== ST_CLEAR || outs !== 4'b1000) begin n_err++; $display("FAIL pause_clear: got state %0d outs %b expected %0d 1000", dbg_state, outs, ST_CLEAR); end
    btn_lap_reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (dbg_state !== ST_IDLE || outs !== 4'b0000 || dbg_pcnt !== 2'd0) begin n_err++; $display("FAIL clear_to_idle: got state %0d outs %b pcnt %0d expected %0d 0000 0", dbg_state, outs, dbg_pcnt, ST_IDLE); end
    repeat (3) @(negedge clk);
    btn_lap_reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 7) btn_lap_reset = 1'b0;
      if (dbg_state !== ST_IDLE || outs !== 4'b0000 || dbg_pcnt !== 2'd0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL idle_lr_ignored: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_simul_and_async_reset();
    int bad;
    do_reset();
    go_run();
    repeat (4) @(negedge clk);
    btn_start_stop = 1'b1;
    btn_lap_reset  = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++; if (dbg_state !== ST_RUN) begin n_err++; $display("FAIL simul_early: got %0d expected %0d", dbg_state, ST_RUN); end
    @(negedge clk);
    n_cmp++; if (dbg_state !== ST_PAUSE || outs !== 4'b0000) begin n_err++; $display("FAIL simul_ss_wins: got state %0d outs %b expected %0d 0000", dbg_state, outs, ST_PAUSE); end
    btn_start_stop = 1'b0;
    btn_lap_reset  = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (dbg_state !== ST_PAUSE) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL simul_lr_dropped: got %0d non-PAUSE cycles expected 0", bad); end
    btn_start_stop = 1'b1;
    repeat (6) @(negedge clk);
    n_cmp++; if (dbg_state !== ST_RUN || outs !== 4'b0001) begin n_err++; $display("FAIL simul_resume: got state %0d outs %b expected %0d 0001", dbg_state, outs, ST_RUN); end
    btn_start_stop = 1'b0;
    @(negedge clk);
    btn_lap_reset = 1'b1;
    repeat (6) @(negedge clk);
    n_cmp++; if (dbg_state !== ST_LAP || outs !== 4'b0011) begin n_err++; $display("FAIL prereset_lap: got state %0d outs %b expected %0d 0011", dbg_state, outs, ST_LAP); end
    btn_lap_reset = 1'b0;
    @(negedge clk);
    #1 res_n = 1'b0;
    #1;
    n_cmp++; if (outs !== 4'b1000 || dbg_state !== ST_CLEAR || dbg_pcnt !== 2'd0) begin n_err++; $display("FAIL async_reset: got outs %b state %0d pcnt %0d expected 1000 %0d 0", outs, dbg_state, dbg_pcnt, ST_CLEAR); end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 res_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (dbg_state !== ST_CLEAR || outs !== 4'b1000) begin n_err++; $display("FAIL post_reset_clear: got state %0d outs %b expected %0d 1000", dbg_state, outs, ST_CLEAR); end
    @(negedge clk);
    n_cmp++; if (dbg_state !== ST_IDLE || outs !== 4'b0000) begin n_err++; $display("FAIL post_reset_idle: got state %0d outs %b expected %0d 0000", dbg_state, outs, ST_IDLE); end
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_start();
    test_glitch();
    test_lap();
    test_pause();
    test_simul_and_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
